alarm_sounder: RTL and testbench

ALARM_SOUNDER -- requirements
Module: alarm_sounder

---
 rtl/alarm_pkg.sv | 12 +
 rtl/tone_gen.sv | 29 ++
 rtl/alarm_sounder.sv | 136 +++++++++++++
 tb/tb_alarm_sounder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sounder: time-code width and the sounder state type.
package alarm_pkg;

  localparam int TIME_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles its output every TONE_HALF enabled cycles,
// and is held silent and cleared whenever it is not enabled.
module tone_gen #(
  parameter int TONE_HALF = 56818
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tone
);

  localparam int CW = $clog2(TONE_HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(TONE_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_sounder.sv
// Alarm sounder: rings a cadenced buzzer when the armed alarm time is reached,
// with snooze, dismiss and an automatic ring timeout.
module alarm_sounder
  import alarm_pkg::*;
#(
  parameter int TONE_HALF    = 56818,
  parameter int RING_TICKS   = 60,
  parameter int SNOOZE_TICKS = 300
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [TIME_W-1:0] alarm_time,
  input  logic              alarm_en,
  input  logic              snooze,
  input  logic              dismiss,
  output logic              buzzer,
  output logic              ringing,
  output logic              snoozed
);

  localparam int RW = $clog2(RING_TICKS + 1);
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  localparam logic [RW-1:0] RING_MAX = RW'(RING_TICKS);
  localparam logic [SW-1:0] SNZ_MAX  = SW'(SNOOZE_TICKS);

  alarm_state_t  state;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic          cadence;
  logic          match_q;
  logic          snooze_q;
  logic          dismiss_q;
  logic          tone;

  logic match;
  logic trigger;
  logic snooze_edge;
  logic dismiss_edge;

  assign match        = alarm_en && (cur_time == alarm_time);
  assign trigger      = match && !match_q;
  assign snooze_edge  = snooze && !snooze_q;
  assign dismiss_edge = dismiss && !dismiss_q;

  tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clock (clock),
    .reset (reset),
    .enable(state == RINGING),
    .tone  (tone)
  );

  // match_q follows match even in reset so a time already matching at release cannot trigger.
  // Tone is always 0 on entry to RINGING, so buzzer starts low on every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      cadence   <= 1'b0;
      match_q   <= match;
      snooze_q  <= 1'b0;
      dismiss_q <= 1'b0;
      ringing   <= 1'b0;
      snoozed   <= 1'b0;
      buzzer    <= 1'b0;
    end else begin
      match_q   <= match;
      snooze_q  <= snooze;
      dismiss_q <= dismiss;
      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= RINGING;
            ring_cnt <= '0;
            cadence  <= 1'b1;
            ringing  <= 1'b1;
            buzzer   <= 1'b0;
          end
        end
        RINGING: begin
          if (!alarm_en || dismiss_edge) begin
            state   <= IDLE;
            cadence <= 1'b0;
            ringing <= 1'b0;
            buzzer  <= 1'b0;
          end else if (snooze_edge) begin
            state   <= SNOOZE;
            snz_cnt <= '0;
            cadence <= 1'b0;
            ringing <= 1'b0;
            snoozed <= 1'b1;
            buzzer  <= 1'b0;
          end else if (ring_cnt == RING_MAX) begin
            state   <= IDLE;
            cadence <= 1'b0;
            ringing <= 1'b0;
            buzzer  <= 1'b0;
          end else if (tick_1hz) begin
            ring_cnt <= ring_cnt + 1'b1;
            cadence  <= ~cadence;
            buzzer   <= tone & ~cadence;
          end else begin
            buzzer <= tone & cadence;
          end
        end
        SNOOZE: begin
          if (!alarm_en || dismiss_edge) begin
            state   <= IDLE;
            snoozed <= 1'b0;
          end else if (snz_cnt == SNZ_MAX) begin
            state    <= RINGING;
            ring_cnt <= '0;
            cadence  <= 1'b1;
            snoozed  <= 1'b0;
            ringing  <= 1'b1;
            buzzer   <= 1'b0;
          end else if (tick_1hz) begin
            snz_cnt <= snz_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cadence <= 1'b0;
          ringing <= 1'b0;
          snoozed <= 1'b0;
          buzzer  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sounder.sv
// Bench for alarm_sounder: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the sounder.
module tb_alarm_sounder;

  localparam int TH = 4;
  localparam int RT = 6;
  localparam int ST = 3;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [8:0] cur_time;
  logic [8:0] alarm_time;
  logic       alarm_en;
  logic       snooze;
  logic       dismiss;
  logic       buzzer;
  logic       ringing;
  logic       snoozed;

  int errors = 0;
  int checks = 0;
  int tick_phase = 0;

  int m_state;
  int m_ring_secs;
  int m_snz_secs;
  int m_tone_edges;
  bit m_cadence;
  bit m_tone;
  bit m_buzzer;
  bit m_match_prev;
  bit m_snz_prev;
  bit m_dis_prev;

  alarm_sounder #(
    .TONE_HALF   (TH),
    .RING_TICKS  (RT),
    .SNOOZE_TICKS(ST)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .cur_time  (cur_time),
    .alarm_time(alarm_time),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .dismiss   (dismiss),
    .buzzer    (buzzer),
    .ringing   (ringing),
    .snoozed   (snoozed)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic enter_ring();
    m_state     = M_RING;
    m_ring_secs = 0;
    m_cadence   = 1'b1;
  endtask

  // Reference behaviour for one clock edge, using the inputs present at that edge.
  task automatic model_step();
    bit match, trig, sedge, dedge, tone_before, was_ring;
    match = alarm_en && (cur_time == alarm_time);
    if (reset) begin
      m_state      = M_IDLE;
      m_ring_secs  = 0;
      m_snz_secs   = 0;
      m_tone_edges = 0;
      m_cadence    = 1'b0;
      m_tone       = 1'b0;
      m_buzzer     = 1'b0;
      m_match_prev = match;
      m_snz_prev   = 1'b0;
      m_dis_prev   = 1'b0;
      return;
    end
    trig        = match && !m_match_prev;
    sedge       = snooze && !m_snz_prev;
    dedge       = dismiss && !m_dis_prev;
    tone_before = m_tone;
    was_ring    = (m_state == M_RING);
    case (m_state)
      M_IDLE: if (trig) enter_ring();
      M_RING: begin
        if (!alarm_en || dedge) m_state = M_IDLE;
        else if (sedge) begin
          m_state    = M_SNZ;
          m_snz_secs = 0;
        end else if (m_ring_secs >= RT) m_state = M_IDLE;
        else if (tick_1hz) begin
          m_ring_secs = (m_ring_secs + 1 > RT) ? RT : m_ring_secs + 1;
          m_cadence   = !m_cadence;
        end
      end
      default: begin
        if (!alarm_en || dedge) m_state = M_IDLE;
        else if (m_snz_secs >= ST) enter_ring();
        else if (tick_1hz) m_snz_secs = (m_snz_secs + 1 > ST) ? ST : m_snz_secs + 1;
      end
    endcase
    if (was_ring) begin
      m_tone_edges++;
      m_tone = ((m_tone_edges / TH) % 2) == 1;
    end else begin
      m_tone_edges = 0;
      m_tone       = 1'b0;
    end
    m_buzzer     = (m_state == M_RING) && tone_before && m_cadence;
    m_match_prev = match;
    m_snz_prev   = snooze;
    m_dis_prev   = dismiss;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz   = (tick_phase == 19);
      tick_phase = (tick_phase + 1) % 20;
      @(posedge clock);
      #1;
      model_step();
      checkOutput("ringing", ringing, m_state == M_RING);
      checkOutput("snoozed", snoozed, m_state == M_SNZ);
      checkOutput("buzzer", buzzer, m_buzzer);
    end
  endtask

  initial begin
    reset      = 1'b1;
    tick_1hz   = 1'b0;
    cur_time   = 9'd0;
    alarm_time = 9'd100;
    alarm_en   = 1'b0;
    snooze     = 1'b0;
    dismiss    = 1'b0;
    applyStimulus(3);
    checkOutput("reset_ringing", ringing, 1'b0);
    checkOutput("reset_buzzer", buzzer, 1'b0);
    reset = 1'b0;

    // Basic ring then automatic timeout with the time still matching
    alarm_en = 1'b1;
    cur_time = 9'd99;
    applyStimulus(5);
    cur_time = 9'd100;
    applyStimulus(1);
    checkOutput("trig_ringing", ringing, 1'b1);
    applyStimulus(200);
    checkOutput("timeout_ringing", ringing, 1'b0);
    checkOutput("timeout_buzzer", buzzer, 1'b0);
    applyStimulus(40);
    checkOutput("no_retrigger", ringing, 1'b0);

    // Held snooze gives one snooze period, then ringing resumes
    cur_time = 9'd99;
    applyStimulus(2);
    cur_time = 9'd100;
    applyStimulus(1);
    checkOutput("retrig_ringing", ringing, 1'b1);
    applyStimulus(10);
    snooze = 1'b1;
    applyStimulus(1);
    checkOutput("snooze_entry", snoozed, 1'b1);
    applyStimulus(99);
    checkOutput("snooze_expired_ringing", ringing, 1'b1);
    checkOutput("snooze_expired_snoozed", snoozed, 1'b0);
    snooze = 1'b0;
    applyStimulus(1);

    // Dismiss beats snooze in the same cycle
    snooze  = 1'b1;
    dismiss = 1'b1;
    applyStimulus(1);
    checkOutput("both_ringing", ringing, 1'b0);
    checkOutput("both_snoozed", snoozed, 1'b0);
    snooze  = 1'b0;
    dismiss = 1'b0;
    applyStimulus(2);

    // Disarm during snooze, then reset during ringing with the time still matching
    cur_time = 9'd99;
    applyStimulus(1);
    cur_time = 9'd100;
    applyStimulus(1);
    snooze = 1'b1;
    applyStimulus(1);
    checkOutput("snooze_again", snoozed, 1'b1);
    alarm_en = 1'b0;
    applyStimulus(1);
    checkOutput("disarm_snoozed", snoozed, 1'b0);
    checkOutput("disarm_ringing", ringing, 1'b0);
    snooze   = 1'b0;
    alarm_en = 1'b1;
    applyStimulus(1);
    checkOutput("rearm_ringing", ringing, 1'b1);
    applyStimulus(25);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("rst_ringing", ringing, 1'b0);
    checkOutput("rst_buzzer", buzzer, 1'b0);
    checkOutput("rst_snoozed", snoozed, 1'b0);
    applyStimulus(1);
    reset = 1'b0;
    applyStimulus(30);
    checkOutput("no_trig_after_reset", ringing, 1'b0);

    // Top time code, arming while the times are already equal
    alarm_en   = 1'b0;
    alarm_time = 9'd511;
    cur_time   = 9'd511;
    applyStimulus(5);
    checkOutput("disarmed_511", ringing, 1'b0);
    alarm_en = 1'b1;
    applyStimulus(1);
    checkOutput("armed_511", ringing, 1'b1);
    dismiss = 1'b1;
    applyStimulus(1);
    checkOutput("dismiss_511", ringing, 1'b0);
    dismiss = 1'b0;
    applyStimulus(2);

    // Random traffic around the alarm time
    alarm_time = 9'($urandom_range(0, 511));
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       cur_time = alarm_time;
          1:       cur_time = alarm_time ^ 9'd1;
          default: cur_time = 9'($urandom_range(0, 511));
        endcase
      end
      if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 29) == 0) snooze = ~snooze;
      if ($urandom_range(0, 59) == 0) dismiss = ~dismiss;
      reset = ($urandom_range(0, 499) == 0);
      applyStimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
